// File: rtl/instr_mem_responder_pkg.sv
// Shared constants, the response entry layout and the address check helper
// for the instruction-memory responder.
package instr_mem_responder_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  // One response as it travels through the pipeline and the FIFO.
  typedef struct packed {
    logic                   err;
    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } resp_entry_t;

  // A request is bad when it is not word aligned or addresses past the array.
  function automatic logic addr_is_bad(input logic [INSTR_WIDTH-1:0] addr,
                                       input int addr_width);
    logic bad;
    bad = (addr[1:0] != 2'b00);
    for (int b = 0; b < INSTR_WIDTH; b++) begin
      if ((b >= addr_width + 2) && addr[b]) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/instr_mem_responder_fifo.sv
// instr_resp_fifo: small in-order synchronous FIFO holding finished responses.
// Head entry is presented combinationally; clear empties it at the next edge.
module instr_resp_fifo
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  resp_entry_t data_i,
  output resp_entry_t data_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  resp_entry_t     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and occupancy; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: credit-limited fetch responder. A request reads the
// instruction array into a fixed-length pipeline; the pipeline tail either
// goes straight to the response port (FIFO empty and fetch ready) or is
// parked in an in-order FIFO. Credits guarantee the FIFO never overflows.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   W_req_valid,
  output logic                   W_req_ready,
  input  logic [INSTR_WIDTH-1:0] W_req_addr,
  output logic                   W_resp_valid,
  input  logic                   W_resp_ready,
  output logic [INSTR_WIDTH-1:0] W_resp_instr,
  output logic [INSTR_WIDTH-1:0] W_resp_pc,
  output logic                   W_resp_err,
  input  logic                   W_flush,
  input  logic                   W_load_en,
  input  logic [ADDR_WIDTH-1:0]  W_load_addr,
  input  logic [INSTR_WIDTH-1:0] W_load_data
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [INSTR_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LATENCY-1:0]     vld_q, vld_d;
  logic                   err_q [LATENCY];
  logic [INSTR_WIDTH-1:0] pc_q  [LATENCY];
  logic [INSTR_WIDTH-1:0] ins_q [LATENCY];

  logic        req_err, accept, rd_en, pop;
  logic        fifo_push, fifo_pop, fifo_empty, fifo_full, resp_valid;
  resp_entry_t last_s, head_s, fifo_dout;

  assign req_err     = addr_is_bad(W_req_addr, ADDR_WIDTH);
  assign W_req_ready = (cnt_q < CW'(DEPTH)) & ~W_flush;
  assign accept      = W_req_valid & W_req_ready;
  assign rd_en       = accept & ~req_err;

  assign resp_valid  = (~fifo_empty | vld_q[LATENCY-1]) & ~W_flush;
  assign pop         = resp_valid & W_resp_ready;
  // Tail bypasses the FIFO only when nothing is queued ahead of it and fetch takes it now.
  assign fifo_push   = vld_q[LATENCY-1] & ~W_flush & ~(fifo_empty & W_resp_ready);
  assign fifo_pop    = ~fifo_empty & W_resp_ready & ~W_flush;

  // Array (read-first registered read) and pipeline payload; no reset needed.
  always_ff @(posedge clk) begin
    if (W_load_en) mem_q[W_load_addr] <= W_load_data;
    if (rd_en) ins_q[0] <= mem_q[W_req_addr[ADDR_WIDTH+1:2]];
    err_q[0] <= req_err;
    pc_q[0]  <= W_req_addr;
    for (int i = 1; i < LATENCY; i++) begin
      err_q[i] <= err_q[i-1];
      pc_q[i]  <= pc_q[i-1];
      ins_q[i] <= ins_q[i-1];
    end
  end

  // Stage valids shift every cycle; flush kills everything in flight.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    if (W_flush) vld_d = '0;
  end

  // Outstanding-request credit count.
  always_comb begin
    cnt_d = cnt_q;
    if (W_flush) cnt_d = '0;
    else begin
      case ({accept, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Pipeline tail as a response entry; errored requests never carry array data.
  always_comb begin
    last_s.err   = err_q[LATENCY-1];
    last_s.pc    = pc_q[LATENCY-1];
    last_s.instr = err_q[LATENCY-1] ? NOP_INSTR : ins_q[LATENCY-1];
  end

  instr_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .clear_i(W_flush),
    .data_i (last_s),
    .data_o (fifo_dout),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Catch a push into a full FIFO, which the credit scheme should make impossible.
  always_ff @(posedge clk) begin
    if (rst) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

  // Response port: FIFO head when queued, otherwise the bypassing tail; zeros when idle.
  always_comb begin
    head_s       = fifo_empty ? last_s : fifo_dout;
    W_resp_valid = resp_valid;
    W_resp_instr = '0;
    W_resp_pc    = '0;
    W_resp_err   = 1'b0;
    if (resp_valid) begin
      W_resp_instr = head_s.instr;
      W_resp_pc    = head_s.pc;
      W_resp_err   = head_s.err;
    end
  end

endmodule
